servisia_sram_arb: RTL and testbench

- Shares the single byte-wide SRAM port between the subservient core and a word-oriented loader/debug requester (UART boot loader, JTAG-style debug).
- The core cannot be stalled, so the loader never interleaves with it. Instead the loader takes exclusive ownership, holds the core in reset, and performs 32-bit accesses as four sequenced byte beats.
- Sits between the core's SRAM interface and the memory instance or external memory pins.

---
 rtl/servisia_sram_arb_if.sv | 25 ++
 rtl/servisia_sram_arb.sv | 151 +++++++++++++++
 tb/tb_servisia_sram_arb.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/servisia_sram_arb_if.sv
// Loader/debug requester port of the SRAM arbiter.
// Word-oriented ownership, command and read-return signals.
interface servisia_sram_arb_if #(
    parameter int AW = 20
);
    logic          req;
    logic          gnt;
    logic          valid;
    logic          ready;
    logic          we;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic          rvalid;
    logic [31:0]   rdata;

    modport master (
        output req, valid, we, addr, wdata,
        input  gnt, ready, rvalid, rdata
    );

    modport slave (
        input  req, valid, we, addr, wdata,
        output gnt, ready, rvalid, rdata
    );
endinterface

// File: rtl/servisia_sram_arb.sv
// Byte-wide SRAM port shared between the core and a word loader.
// The loader owns the port exclusively and keeps the core in reset.
module servisia_sram_arb #(
    parameter int AW        = 20,
    parameter bit BOOT_HOLD = 1'b0
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [AW-1:0] core_waddr_i,
    input  logic [7:0]    core_wdata_i,
    input  logic          core_wen_i,
    input  logic [AW-1:0] core_raddr_i,
    input  logic          core_ren_i,
    output logic [7:0]    core_rdata_o,
    output logic          core_rst_o,
    servisia_sram_arb_if.slave ldr,
    output logic [AW-1:0] mem_addr_o,
    output logic [7:0]    mem_wdata_o,
    output logic          mem_write_o,
    output logic          mem_read_o,
    input  logic [7:0]    mem_rdata_i
);

    typedef enum logic [2:0] {
        CORE,
        LDR_IDLE,
        LDR_WR,
        LDR_RD,
        LDR_RDLAST
    } state_t;

    localparam state_t RST_STATE = BOOT_HOLD ? LDR_IDLE : CORE;

    state_t        state;
    state_t        state_nx;
    logic [1:0]    beat;
    logic [AW-1:0] addr_q;
    logic [31:0]   wdata_q;
    logic          we_q;
    logic [31:0]   rdata_q;
    logic [AW-1:0] beat_addr;

    // Low address bits are held at zero, so OR-ing the beat never carries.
    assign beat_addr    = addr_q | AW'(beat);
    assign core_rdata_o = mem_rdata_i;
    assign core_rst_o   = rst_i | (state != CORE);

    // Final byte is forwarded straight from the SRAM during the last cycle.
    assign ldr.rdata  = (state == LDR_RDLAST) ?
                        {mem_rdata_i, rdata_q[23:0]} : rdata_q;
    assign ldr.rvalid = (state == LDR_RDLAST);

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= RST_STATE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic; a new command wins over a same-cycle req drop.
    always_comb begin
        state_nx = state;
        unique case (state)
            CORE: begin
                if (ldr.req) state_nx = LDR_IDLE;
            end
            LDR_IDLE: begin
                if (ldr.valid) begin
                    state_nx = ldr.we ? LDR_WR : LDR_RD;
                end else if (!ldr.req) begin
                    state_nx = CORE;
                end
            end
            LDR_WR: begin
                if (beat == 2'd3) state_nx = LDR_IDLE;
            end
            LDR_RD: begin
                if (beat == 2'd3) state_nx = LDR_RDLAST;
            end
            LDR_RDLAST: state_nx = LDR_IDLE;
            default:    state_nx = RST_STATE;
        endcase
    end

    // Output logic: core passthrough in CORE, loader byte beats otherwise.
    always_comb begin
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        mem_write_o = 1'b0;
        mem_read_o  = 1'b0;
        ldr.gnt     = 1'b1;
        ldr.ready   = 1'b0;
        unique case (state)
            CORE: begin
                ldr.gnt     = 1'b0;
                mem_addr_o  = core_wen_i ? core_waddr_i : core_raddr_i;
                mem_wdata_o = core_wdata_i;
                mem_write_o = core_wen_i;
                mem_read_o  = core_ren_i;
            end
            LDR_IDLE: ldr.ready = 1'b1;
            LDR_WR: begin
                mem_write_o = 1'b1;
                mem_addr_o  = beat_addr;
                mem_wdata_o = wdata_q[{beat, 3'b000} +: 8];
            end
            LDR_RD: begin
                mem_read_o = 1'b1;
                mem_addr_o = beat_addr;
            end
            default: ;
        endcase
    end

    // Command capture, beat sequencing and read-word assembly.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            beat    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            rdata_q <= '0;
        end else begin
            unique case (state)
                LDR_IDLE: begin
                    if (ldr.valid) begin
                        addr_q  <= ldr.addr & ~AW'(3);
                        wdata_q <= ldr.wdata;
                        we_q    <= ldr.we;
                        beat    <= '0;
                    end
                end
                LDR_WR: beat <= beat + 2'd1;
                LDR_RD: begin
                    beat <= beat + 2'd1;
                    if (beat != 2'd0) begin
                        rdata_q[{beat - 2'd1, 3'b000} +: 8] <= mem_rdata_i;
                    end
                end
                LDR_RDLAST: rdata_q[31:24] <= mem_rdata_i;
                default: ;
            endcase
        end
    end

    logic unused_we;
    assign unused_we = we_q;

endmodule

// File: tb/tb_servisia_sram_arb.sv
// Bench for servisia_sram_arb: scoreboard on loader beats,
// direct checks on passthrough, ownership and boot-hold.
module tb_servisia_sram_arb;

    localparam int AW = 20;

    typedef struct {
        int          kind;
        logic [AW-1:0] addr;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    exp_t sb[$];
    logic [7:0] model [int];

    // DUT 0: core owns SRAM after reset
    logic [AW-1:0] core_waddr = '0, core_raddr = '0;
    logic [7:0]    core_wdata = '0;
    logic          core_wen = 1'b0, core_ren = 1'b0;
    logic [7:0]    core_rdata;
    logic          core_rst;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata;
    logic          mem_write, mem_read;
    logic [7:0]    mem_rdata = '0;
    servisia_sram_arb_if #(.AW(AW)) bus0 ();

    servisia_sram_arb #(.AW(AW), .BOOT_HOLD(1'b0)) dut0 (
        .clk_i(clk), .rst_i(rst),
        .core_waddr_i(core_waddr), .core_wdata_i(core_wdata),
        .core_wen_i(core_wen), .core_raddr_i(core_raddr),
        .core_ren_i(core_ren), .core_rdata_o(core_rdata),
        .core_rst_o(core_rst), .ldr(bus0.slave),
        .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
        .mem_write_o(mem_write), .mem_read_o(mem_read),
        .mem_rdata_i(mem_rdata)
    );

    // DUT 1: boot-hold variant
    logic [AW-1:0] zaddr = '0;
    logic [7:0]    zbyte = '0;
    logic          zbit = 1'b0;
    logic [7:0]    core_rdata1;
    logic          core_rst1;
    logic [AW-1:0] mem_addr1;
    logic [7:0]    mem_wdata1;
    logic          mem_write1, mem_read1;
    servisia_sram_arb_if #(.AW(AW)) bus1 ();

    servisia_sram_arb #(.AW(AW), .BOOT_HOLD(1'b1)) dut1 (
        .clk_i(clk), .rst_i(rst),
        .core_waddr_i(zaddr), .core_wdata_i(zbyte),
        .core_wen_i(zbit), .core_raddr_i(zaddr),
        .core_ren_i(zbit), .core_rdata_o(core_rdata1),
        .core_rst_o(core_rst1), .ldr(bus1.slave),
        .mem_addr_o(mem_addr1), .mem_wdata_o(mem_wdata1),
        .mem_write_o(mem_write1), .mem_read_o(mem_read1),
        .mem_rdata_i(zbyte)
    );

    // SRAM model for DUT 0: read data valid the cycle after the strobe
    always @(posedge clk) begin
        if (mem_read) begin
            mem_rdata <= model.exists(int'(mem_addr)) ?
                         model[int'(mem_addr)] : 8'h00;
        end
        if (mem_write) model[int'(mem_addr)] = mem_wdata;
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int kind, input logic [AW-1:0] a,
                        input logic [31:0] d);
        exp_t e;
        e.kind = kind;
        e.addr = a;
        e.data = d;
        sb.push_back(e);
    endtask

    // Monitor: loader beats and read-word returns vs scoreboard
    always @(negedge clk) begin
        exp_t e;
        if (bus0.gnt === 1'b1 && (mem_write || mem_read)) begin
            if (sb.size() == 0) begin
                check("unexpected_beat", {mem_write, mem_read}, 32'h0);
            end else begin
                e = sb.pop_front();
                check("beat_kind", mem_write ? 0 : 1, e.kind);
                check("beat_addr", 32'(mem_addr), 32'(e.addr));
                if (mem_write) check("beat_wdata", 32'(mem_wdata), e.data);
            end
        end
        if (bus0.rvalid === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_rvalid", 32'(bus0.rdata), 32'h0);
            end else begin
                e = sb.pop_front();
                check("rvalid_kind", 2, e.kind);
                check("rvalid_rdata", bus0.rdata, e.data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] bw;
        bus0.req = 0; bus0.valid = 0; bus0.we = 0;
        bus0.addr = '0; bus0.wdata = '0;
        bus1.req = 1; bus1.valid = 0; bus1.we = 0;
        bus1.addr = '0; bus1.wdata = '0;
        model[32'h10]  = 8'hA5;
        model[32'h200] = 8'h11;
        model[32'h201] = 8'h22;
        model[32'h202] = 8'h33;
        model[32'h203] = 8'h44;

        step(); step();
        @(negedge clk);
        check("core_rst_in_reset", core_rst, 1);
        rst = 0;
        @(negedge clk);
        check("rst_core_rst", core_rst, 0);
        check("rst_gnt", bus0.gnt, 0);
        check("rst_ready", bus0.ready, 0);
        check("rst_rvalid", bus0.rvalid, 0);
        check("rst_rdata", bus0.rdata, 32'h0);
        check("boot_gnt", bus1.gnt, 1);
        check("boot_core_rst", core_rst1, 1);

        // Boot-hold: load a word, then release the core
        bus1.valid = 1; bus1.we = 1;
        bus1.addr = 20'h00041; bus1.wdata = 32'hCAFEF00D;
        bw = 32'hCAFEF00D;
        step();
        bus1.valid = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("boot_write", mem_write1, 1);
            check("boot_addr", 32'(mem_addr1), 32'h40 + i);
            check("boot_wdata", 32'(mem_wdata1), 32'(bw[8*i +: 8]));
            step();
        end
        bus1.req = 0;
        step();
        @(negedge clk);
        check("boot_release_rst", core_rst1, 0);
        check("boot_release_gnt", bus1.gnt, 0);

        // Core passthrough
        core_ren = 1; core_raddr = 20'h00010;
        @(negedge clk);
        check("pt_read", mem_read, 1);
        check("pt_raddr", 32'(mem_addr), 32'h10);
        step();
        @(negedge clk);
        check("pt_rdata", 32'(core_rdata), 32'hA5);
        core_wen = 1; core_waddr = 20'h00020; core_wdata = 8'h5A;
        @(negedge clk);
        check("pt_write", mem_write, 1);
        check("pt_waddr", 32'(mem_addr), 32'h20);
        check("pt_wdata", 32'(mem_wdata), 32'h5A);

        // Ownership: core strobes blocked while loader owns SRAM
        bus0.req = 1;
        step();
        @(negedge clk);
        check("own_gnt", bus0.gnt, 1);
        check("own_core_rst", core_rst, 1);
        check("own_strobes", {mem_write, mem_read}, 0);
        check("own_ready", bus0.ready, 1);
        bus0.req = 0;
        step();
        @(negedge clk);
        check("rel_gnt", bus0.gnt, 0);
        check("rel_core_rst", core_rst, 0);
        core_wen = 0; core_ren = 0;

        // Word write, unaligned address
        bus0.req = 1;
        step();
        bus0.valid = 1; bus0.we = 1;
        bus0.addr = 20'h00103; bus0.wdata = 32'hDEADBEEF;
        push(0, 20'h00100, 32'hEF);
        push(0, 20'h00101, 32'hBE);
        push(0, 20'h00102, 32'hAD);
        push(0, 20'h00103, 32'hDE);
        step();
        bus0.valid = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("wr_ready_low", bus0.ready, 0);
            step();
        end
        @(negedge clk);
        check("wr_ready_back", bus0.ready, 1);

        // Word read
        bus0.valid = 1; bus0.we = 0; bus0.addr = 20'h00200;
        for (int i = 0; i < 4; i++) push(1, 20'h00200 + AW'(i), 0);
        push(2, '0, 32'h44332211);
        step();
        bus0.valid = 0;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            check("rd_rvalid_timing", bus0.rvalid, (i == 5));
            step();
        end
        check("rd_rdata_hold", bus0.rdata, 32'h44332211);

        // Req drop mid-write at top of memory
        bus0.valid = 1; bus0.we = 1;
        bus0.addr = 20'hFFFFE; bus0.wdata = 32'h01020304;
        push(0, 20'hFFFFC, 32'h04);
        push(0, 20'hFFFFD, 32'h03);
        push(0, 20'hFFFFE, 32'h02);
        push(0, 20'hFFFFF, 32'h01);
        step();
        bus0.valid = 0;
        step();
        bus0.req = 0;
        step(); step(); step();
        @(negedge clk);
        check("drop_idle_gnt", bus0.gnt, 1);
        check("drop_idle_ready", bus0.ready, 1);
        step();
        @(negedge clk);
        check("drop_core_gnt", bus0.gnt, 0);
        check("drop_core_rst", core_rst, 0);

        // Reset during read beat 2
        bus0.req = 1;
        step();
        bus0.valid = 1; bus0.we = 0; bus0.addr = 20'h00200;
        for (int i = 0; i < 3; i++) push(1, 20'h00200 + AW'(i), 0);
        step();
        bus0.valid = 0;
        step(); step();
        rst = 1; bus0.req = 0;
        @(negedge clk);
        check("mid_rst_core_rst", core_rst, 1);
        step();
        @(negedge clk);
        check("mid_rst_core_rst2", core_rst, 1);
        check("mid_rst_gnt", bus0.gnt, 0);
        check("mid_rst_rvalid", bus0.rvalid, 0);
        check("mid_rst_rdata", bus0.rdata, 32'h0);
        rst = 0;
        step();
        @(negedge clk);
        check("post_rst_core_rst", core_rst, 0);
        for (int i = 0; i < 4; i++) step();
        check("sb_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
